aes_ct_serializer: RTL and testbench



---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_blk_hold.sv | 39 +++
 rtl/aes_ct_serializer.sv | 153 +++++++++++++++
 tb/tb_aes_ct_serializer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath types: block geometry, the 128-bit block type and the
// ciphertext serializer state encoding.
package aes_pkg;

    localparam int AES_BLOCK_BITS  = 128;
    localparam int AES_BLOCK_BYTES = 16;

    typedef logic [AES_BLOCK_BITS-1:0] aes_block_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/aes_blk_hold.sv
// One-entry valid/data holding register for a ciphertext block; load and
// unload are never asserted together by the serializer.
module aes_blk_hold
    import aes_pkg::*;
#(
    parameter int W = AES_BLOCK_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         unload_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Holding register: capture on load, release on unload.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
            data_q  <= data_q;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/aes_ct_serializer.sv
// Ciphertext block-to-byte serializer with valid/ready on both sides.
// Define AES_CT_SERIALIZER_DBUF_EN for a one-entry block holding register.
module aes_ct_serializer
    import aes_pkg::*;
#(
    parameter int BLOCK_BITS = AES_BLOCK_BITS,
    parameter int BYTE_BITS  = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  blk_valid,
    input  logic [BLOCK_BITS-1:0] blk_data,
    output logic                  blk_ready,
    output logic                  byte_valid,
    output logic [BYTE_BITS-1:0]  byte_out,
    input  logic                  byte_ready,
    output logic                  last,
    output logic                  busy
);

    localparam int NBYTES = BLOCK_BITS / BYTE_BITS;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

    ser_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BLOCK_BITS-1:0] shreg_q, shreg_d, shift_s;
    logic                  blk_ready_q, blk_ready_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  blk_hs_s, byte_hs_s, final_hs_s;

    assign blk_hs_s   = blk_valid && blk_ready;
    assign byte_hs_s  = (state_q == SEND) && byte_ready;
    assign final_hs_s = byte_hs_s && (cnt_q == CNT_LAST);

    if (MSB_FIRST) begin : g_msb
        assign shift_s  = shreg_q << BYTE_BITS;
        assign byte_out = shreg_q[BLOCK_BITS-1 -: BYTE_BITS];
    end else begin : g_lsb
        assign shift_s  = shreg_q >> BYTE_BITS;
        assign byte_out = shreg_q[BYTE_BITS-1:0];
    end

`ifdef AES_CT_SERIALIZER_DBUF_EN
    logic                  hold_valid_s, hold_valid_nxt_s;
    logic                  hold_load_s, hold_unload_s;
    logic [BLOCK_BITS-1:0] hold_data_s;

    // A block offered mid-stream parks in the holding register unless the
    // shift register frees up on this very edge, in which case it loads directly.
    assign hold_load_s      = blk_hs_s && (state_q == SEND) && !final_hs_s;
    assign hold_unload_s    = final_hs_s && hold_valid_s;
    assign hold_valid_nxt_s = hold_load_s || (hold_valid_s && !hold_unload_s);

    aes_blk_hold #(
        .W (BLOCK_BITS)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load_i   (hold_load_s),
        .unload_i (hold_unload_s),
        .data_i   (blk_data),
        .valid_o  (hold_valid_s),
        .data_o   (hold_data_s)
    );
`endif

    // Next-state, byte counter and shift register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (blk_hs_s) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    shreg_d = blk_data;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (final_hs_s) begin
                    cnt_d = '0;
`ifdef AES_CT_SERIALIZER_DBUF_EN
                    if (hold_valid_s) begin
                        shreg_d = hold_data_s;
                    end else if (blk_hs_s) begin
                        shreg_d = blk_data;
                    end else begin
                        state_d = IDLE;
                        shreg_d = shift_s;
                    end
`else
                    state_d = IDLE;
                    shreg_d = shift_s;
`endif
                end else if (byte_hs_s) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    shreg_d = shift_s;
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                shreg_d = '0;
            end
        endcase
    end

    // Registered status outputs derived from the next state.
    always_comb begin
        last_d = (state_d == SEND) && (cnt_d == CNT_LAST);
`ifdef AES_CT_SERIALIZER_DBUF_EN
        blk_ready_d = !hold_valid_nxt_s;
        busy_d      = (state_d == SEND) || hold_valid_nxt_s;
`else
        blk_ready_d = (state_d == IDLE);
        busy_d      = (state_d == SEND);
`endif
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            blk_ready_q <= 1'b1;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            blk_ready_q <= blk_ready_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
        end
    end

    // Ready is forced low while reset is held so no block is taken during reset.
    assign blk_ready  = blk_ready_q && !rst;
    assign byte_valid = (state_q == SEND);
    assign last       = last_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Directed self-checking bench for aes_ct_serializer (MSB-first and LSB-first
// instances); expected cycle counts follow AES_CT_SERIALIZER_DBUF_EN.
module tb_aes_ct_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid, blk_ready, byte_valid, byte_ready, last, busy;
    logic [127:0] blk_data;
    logic [7:0]   byte_out;
    logic         l_blk_valid, l_blk_ready, l_byte_valid, l_byte_ready, l_last, l_busy;
    logic [127:0] l_blk_data;
    logic [7:0]   l_byte_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] tx_q[$];
    logic [7:0]   rx_exp_q[$];

    localparam logic [127:0] CT_BLK  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B2_BLK  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] LSB_BLK = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [7:0] CT_BYTES [16] = '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
                                             8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};
    localparam logic [7:0] B2_BYTES [16] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                                             8'h88, 8'h99, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff};
    localparam logic [7:0] LSB_BYTES [16] = '{8'h0f, 8'h0e, 8'h0d, 8'h0c, 8'h0b, 8'h0a, 8'h09, 8'h08,
                                              8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

`ifdef AES_CT_SERIALIZER_DBUF_EN
    localparam int B2B_LAST_CYC = 32;
`else
    localparam int B2B_LAST_CYC = 33;
`endif

    always #5 clk = ~clk;

    aes_ct_serializer #(.BLOCK_BITS(128), .BYTE_BITS(8), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready),
        .byte_valid(byte_valid), .byte_out(byte_out), .byte_ready(byte_ready), .last(last), .busy(busy)
    );

    aes_ct_serializer #(.BLOCK_BITS(128), .BYTE_BITS(8), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .rst(rst), .blk_valid(l_blk_valid), .blk_data(l_blk_data), .blk_ready(l_blk_ready),
        .byte_valid(l_byte_valid), .byte_out(l_byte_out), .byte_ready(l_byte_ready), .last(l_last),
        .busy(l_busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] b [16]);
        for (int i = 0; i < 16; i++) rx_exp_q.push_back(b[i]);
    endtask

    // Offers tx_q blocks and consumes bytes until max_bytes handshakes; called at a negedge.
    task automatic run_traffic(input string tag, input bit stall, input int max_bytes,
                               output int first_cyc, output int last_cyc);
        int cyc   = 0;
        int taken = 0;
        first_cyc = -1;
        last_cyc  = -1;
        while (taken < max_bytes && cyc < 400) begin
            blk_valid  = (tx_q.size() > 0);
            blk_data   = (tx_q.size() > 0) ? tx_q[0] : {$urandom, $urandom, $urandom, $urandom};
            byte_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (byte_valid && rx_exp_q.size() > 0) begin
                check({tag, "_byte"}, byte_out, rx_exp_q[0]);
                check({tag, "_last"}, last, (rx_exp_q.size() % 16 == 1));
                if (byte_ready) begin
                    void'(rx_exp_q.pop_front());
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    taken++;
                end
            end
            if (blk_valid && blk_ready) void'(tx_q.pop_front());
            @(negedge clk);
            cyc++;
        end
        if (taken < max_bytes) check({tag, "_timeout"}, taken, max_bytes);
        blk_valid  = 1'b0;
        byte_ready = 1'b1;
    endtask

    initial begin
        int fc, lc;
        rst = 1'b1;
        blk_valid = 1'b0; blk_data = '0; byte_ready = 1'b0;
        l_blk_valid = 1'b0; l_blk_data = '0; l_byte_ready = 1'b0;

        // Reset: two cycles held, outputs quiet, ready low until release.
        @(posedge clk); @(negedge clk);
        check("rst_blk_ready", blk_ready, 1'b0);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_byte_out", byte_out, 8'h00);
        check("rst_last", last, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk); @(negedge clk);
        check("rst2_blk_ready", blk_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_blk_ready", blk_ready, 1'b1);
        check("post_rst_byte_valid", byte_valid, 1'b0);

        // Single FIPS-197 ciphertext block at full rate.
        tx_q.push_back(CT_BLK);
        push_exp(CT_BYTES);
        run_traffic("single", 1'b0, 16, fc, lc);
        check("single_first_cyc", fc, 1);
        check("single_last_cyc", lc, 16);
        check("single_idle_valid", byte_valid, 1'b0);
        check("single_idle_busy", busy, 1'b0);

        // Random back-pressure: same sequence, held stable while stalled.
        tx_q.push_back(CT_BLK);
        push_exp(CT_BYTES);
        run_traffic("stall", 1'b1, 16, fc, lc);
        check("stall_idle_valid", byte_valid, 1'b0);

        // Two blocks offered back to back.
        tx_q.push_back(CT_BLK);
        tx_q.push_back(B2_BLK);
        push_exp(CT_BYTES);
        push_exp(B2_BYTES);
        run_traffic("b2b", 1'b0, 32, fc, lc);
        check("b2b_first_cyc", fc, 1);
        check("b2b_last_cyc", lc, B2B_LAST_CYC);

        // Reset after byte 5 with a second block pending.
        tx_q.push_back(B2_BLK);
        tx_q.push_back(CT_BLK);
        push_exp(B2_BYTES);
        push_exp(CT_BYTES);
        run_traffic("pre_rst", 1'b0, 6, fc, lc);
        rst = 1'b1;
        blk_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_byte_valid", byte_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_last", last, 1'b0);
        rst = 1'b0;
        tx_q.delete();
        rx_exp_q.delete();
        @(negedge clk);
        check("after_rst_byte_valid", byte_valid, 1'b0);
        tx_q.push_back(CT_BLK);
        push_exp(CT_BYTES);
        run_traffic("fresh", 1'b0, 16, fc, lc);
        check("fresh_first_cyc", fc, 1);
        check("fresh_last_cyc", lc, 16);

        // LSB-first instance: bytes emitted from blk_data[7:0] upward.
        check("lsb_blk_ready", l_blk_ready, 1'b1);
        l_blk_valid = 1'b1; l_blk_data = LSB_BLK; l_byte_ready = 1'b1;
        @(negedge clk);
        l_blk_valid = 1'b0; l_blk_data = '1;
        for (int k = 0; k < 16; k++) begin
            check("lsb_valid", l_byte_valid, 1'b1);
            check("lsb_byte", l_byte_out, LSB_BYTES[k]);
            check("lsb_last", l_last, (k == 15));
            @(negedge clk);
        end
        check("lsb_idle_valid", l_byte_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
